cache_miss_ctrl: RTL and testbench
==================================

Name: cache_miss_ctrl

Overview:
- Miss-handling sequencer for the set-associative cache. Sits directly upstream of the tree-PLRU array: it issues the PLRU read, consumes the returned victim way and drives the PLRU load that marks the filled way most-recently-used.
- Selects a victim and writes it back to memory if it is dirty. Fetches the missing line from memory, presents it to the tag/data arrays for write, then returns to idle.

Parameters:
- s_index, 3, set index width; num_sets = 2**s_index.
- way_bits, 3, way index width; num_ways = 2**way_bits.
- s_tag, 24, tag width.
- s_offset, 5, byte-offset width; s_line = 8*2**s_offset = 256.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  miss request from hit logic.
- req_ready  out  1  high only in IDLE.
- req_index  in  s_index  set index of miss.
- req_tag  in  s_tag  tag of miss.
- lru_read  out  1  PLRU read strobe.
- lru_rindex  out  s_index  PLRU read index.
- lru_way  in  way_bits  PLRU victim; valid the cycle after lru_read.
- lru_load  out  1  PLRU update strobe.
- lru_windex  out  s_index  PLRU update index.
- lru_datain  out  way_bits  way to mark MRU.
- way_valid  in  num_ways  valid bits of the requested set; valid in LOOKUP.
- way_dirty  in  num_ways  dirty bits of the requested set; valid in LOOKUP.
- way_tags  in  num_ways*s_tag  tags of the set; way w occupies bits [w*s_tag +: s_tag]; valid in LOOKUP.
- victim_rdata  in  s_line  data line of the chosen victim; valid in LOOKUP, combinational on victim choice.
- mem_read  out  1  line read request.
- mem_write  out  1  line write request.
- mem_addr  out  s_tag+s_index+s_offset  line address, offset bits zero.
- mem_wdata  out  s_line  writeback data.
- mem_rdata  in  s_line  fill data, valid with mem_resp.
- mem_resp  in  1  memory completion.
- fill_we  out  1  tag/data/valid array write strobe; also clears dirty.
- fill_index  out  s_index  index for the array write.
- fill_way  out  way_bits  way for the array write.
- fill_tag  out  s_tag  tag for the array write.
- fill_data  out  s_line  data for the array write.
- miss_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, asynchronous): state is IDLE. All strobes (lru_read, lru_load, mem_read, mem_write, fill_we, miss_done) are 0 immediately. All latched index/tag/way/data registers are 0. An in-flight memory transaction is abandoned and its late mem_resp is ignored.
- State IDLE: req_ready=1.
  - If req_valid: latch req_index and req_tag, pulse lru_read=1 with lru_rindex=req_index in the same cycle, go to LOOKUP.
  - Otherwise stay in IDLE.
- State LOOKUP (1 cycle):
  - Victim is the lowest-numbered way with way_valid=0 if any exists; otherwise lru_way.
  - Latch the victim way, way_tags of the victim and victim_rdata.
  - If the victim is valid and dirty, go to WRITEBACK; else go to FILL.
- State WRITEBACK:
  - mem_write=1, mem_addr={victim_tag, index, 0}, mem_wdata=latched line. All held stable until mem_resp.
  - On mem_resp, deassert mem_write and go to FILL.
- State FILL:
  - mem_read=1, mem_addr={req_tag, index, 0}, held until mem_resp.
  - On mem_resp, latch mem_rdata and go to UPDATE.
- State UPDATE (1 cycle):
  - fill_we=1 with fill_index, fill_way, fill_tag=req_tag and fill_data=latched line.
  - lru_load=1 with lru_windex=index and lru_datain=victim way.
  - miss_done=1. Go to IDLE.
- Strobe rules: mem_read and mem_write are never high together. mem_resp is ignored in IDLE, LOOKUP and UPDATE.
- Latency:
  - Clean miss: 3 cycles plus memory latency from request acceptance to miss_done.
  - Dirty miss: 4 cycles plus two memory latencies.
  - Back-to-back requests: next acceptance no earlier than the cycle after miss_done.
- Requests in any state other than IDLE are not accepted (req_ready=0); the requester holds req_valid.

Test Plan:
- Reset during FILL with mem_read high -> mem_read drops with no clock edge; after release, req_ready=1; a mem_resp 2 cycles later causes no fill_we.
- Set 5, all ways valid/clean, lru_way=3'd6, req_tag=24'hABCDEF -> one lru_read with rindex=5; mem_read with addr={24'hABCDEF,3'd5,5'd0}; after mem_resp, fill_we with way 6 and lru_load with windex=5, datain=6, single miss_done.
- Set 2, way_valid=8'b1111_0111, lru_way=0 -> victim way 3, no WRITEBACK, fill_way=3, lru_datain=3.
- Set 1, all valid, way 4 dirty with tag 24'h000123, lru_way=4 -> mem_write with addr={24'h000123,3'd1,5'd0} and wdata=victim line; then mem_read for the new tag; never both strobes high.
- mem_resp delayed 10 cycles in WRITEBACK with req_valid held -> addr and wdata stable throughout, req_ready=0; completion follows the FILL response.
- Two consecutive misses -> second accepted only the cycle after miss_done; stray mem_resp in IDLE -> no state change.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss-handling sequencer for the set-associative cache.
// It reads the tree-PLRU for a victim and picks the lowest invalid way before
// falling back to the PLRU choice. A valid, dirty victim is written back first.
// The missing line is then fetched, written into the tag/data arrays, and the
// filled way is marked most-recently-used in the PLRU.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/ready/index/tag miss request from the hit logic
//   lru_read/rindex/way       PLRU victim read (way returned one cycle later)
//   lru_load/windex/datain    PLRU MRU update
//   way_valid/dirty/tags      per-way state of the requested set (LOOKUP)
//   victim_rdata              data line of the way currently on fill_way
//   mem_*                     line read/write interface to memory
//   fill_*                    tag/data/valid array write (also clears dirty)
//   miss_done                 one-cycle completion pulse
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a miss; lru_read issued on acceptance
// LOOKUP    | choose victim, latch its tag and data line
// WRITEBACK | mem_write of the dirty victim until mem_resp
// FILL      | mem_read of the missing line until mem_resp
// UPDATE    | array write, PLRU update, miss_done pulse
module cache_miss_ctrl #(
  parameter  int s_index  = 3,
  parameter  int way_bits = 3,
  parameter  int s_tag    = 24,
  parameter  int s_offset = 5,
  localparam int num_ways = 2**way_bits,
  localparam int s_line   = 8 * (2**s_offset),
  localparam int s_addr   = s_tag + s_index + s_offset
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [s_index-1:0]        req_index,
  input  logic [s_tag-1:0]          req_tag,
  output logic                      lru_read,
  output logic [s_index-1:0]        lru_rindex,
  input  logic [way_bits-1:0]       lru_way,
  output logic                      lru_load,
  output logic [s_index-1:0]        lru_windex,
  output logic [way_bits-1:0]       lru_datain,
  input  logic [num_ways-1:0]       way_valid,
  input  logic [num_ways-1:0]       way_dirty,
  input  logic [num_ways*s_tag-1:0] way_tags,
  input  logic [s_line-1:0]         victim_rdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [s_addr-1:0]         mem_addr,
  output logic [s_line-1:0]         mem_wdata,
  input  logic [s_line-1:0]         mem_rdata,
  input  logic                      mem_resp,
  output logic                      fill_we,
  output logic [s_index-1:0]        fill_index,
  output logic [way_bits-1:0]       fill_way,
  output logic [s_tag-1:0]          fill_tag,
  output logic [s_line-1:0]         fill_data,
  output logic                      miss_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_UPDATE
  } state_t;

  state_t                r_state;
  logic [s_index-1:0]    r_index;
  logic [s_tag-1:0]      r_tag;
  logic [way_bits-1:0]   r_way;
  logic [s_tag-1:0]      r_vtag;
  // Holds the victim line during writeback, then the fill line.
  logic [s_line-1:0]     r_line;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_fill_we;
  logic                  r_lru_load;
  logic                  r_miss_done;

  logic                  w_has_free;
  logic [way_bits-1:0]   w_free_way;
  logic [way_bits-1:0]   w_victim;
  logic                  w_victim_dirty;
  logic [s_tag-1:0]      w_victim_tag;

  // Lowest-numbered invalid way; scanning downward leaves the lowest one last.
  always_comb begin
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        w_has_free = 1'b1;
        w_free_way = way_bits'(w);
      end
    end
  end

  assign w_victim       = w_has_free ? w_free_way : lru_way;
  assign w_victim_dirty = way_valid[w_victim] & way_dirty[w_victim];
  assign w_victim_tag   = way_tags[w_victim*s_tag +: s_tag];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_tag       <= '0;
      r_way       <= '0;
      r_vtag      <= '0;
      r_line      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_fill_we   <= 1'b0;
      r_lru_load  <= 1'b0;
      r_miss_done <= 1'b0;
    end else begin
      r_fill_we   <= 1'b0;
      r_lru_load  <= 1'b0;
      r_miss_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_index <= req_index;
            r_tag   <= req_tag;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_way  <= w_victim;
          r_vtag <= w_victim_tag;
          r_line <= victim_rdata;
          if (w_victim_dirty) begin
            r_mem_write <= 1'b1;
            r_state     <= S_WRITEBACK;
          end else begin
            r_mem_read <= 1'b1;
            r_state    <= S_FILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_resp) begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_resp) begin
            r_line      <= mem_rdata;
            r_mem_read  <= 1'b0;
            r_fill_we   <= 1'b1;
            r_lru_load  <= 1'b1;
            r_miss_done <= 1'b1;
            r_state     <= S_UPDATE;
          end
        end
        S_UPDATE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    case (r_state)
      S_WRITEBACK: mem_addr = {r_vtag, r_index, {s_offset{1'b0}}};
      S_FILL:      mem_addr = {r_tag,  r_index, {s_offset{1'b0}}};
      default:     mem_addr = '0;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign lru_read   = (r_state == S_IDLE) & req_valid;
  assign lru_rindex = req_index;
  assign lru_load   = r_lru_load;
  assign lru_windex = r_index;
  assign lru_datain = r_way;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_wdata  = r_line;
  assign fill_we    = r_fill_we;
  assign fill_index = r_index;
  // During LOOKUP the data array reads the way being chosen, so the live
  // victim choice is presented here before it is latched.
  assign fill_way   = (r_state == S_LOOKUP) ? w_victim : r_way;
  assign fill_tag   = r_tag;
  assign fill_data  = r_line;
  assign miss_done  = r_miss_done;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;

  logic          clk, rst;
  logic          req_valid, req_ready;
  logic [2:0]    req_index;
  logic [23:0]   req_tag;
  logic          lru_read, lru_load;
  logic [2:0]    lru_rindex, lru_way, lru_windex, lru_datain;
  logic [7:0]    way_valid, way_dirty;
  logic [191:0]  way_tags;
  logic [255:0]  victim_rdata, mem_wdata, mem_rdata, fill_data;
  logic          mem_read, mem_write, mem_resp, fill_we, miss_done;
  logic [31:0]   mem_addr;
  logic [2:0]    fill_index, fill_way;
  logic [23:0]   fill_tag;

  int n_checks = 0;
  int n_err    = 0;

  cache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_tag(req_tag),
    .lru_read(lru_read), .lru_rindex(lru_rindex), .lru_way(lru_way),
    .lru_load(lru_load), .lru_windex(lru_windex), .lru_datain(lru_datain),
    .way_valid(way_valid), .way_dirty(way_dirty), .way_tags(way_tags),
    .victim_rdata(victim_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .fill_we(fill_we), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_data(fill_data), .miss_done(miss_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] vline(input logic [2:0] w);
    return {8{32'hA5A50000 | 32'(w)}};
  endfunction

  function automatic logic [255:0] fline(input int k);
    return {8{32'hF00D0000 + 32'(k)}};
  endfunction

  // Data array model: returns the line of whichever way is on fill_way.
  assign victim_rdata = vline(fill_way);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      n_checks++;
      if (mem_read && mem_write) begin
        n_err++;
        $display("FAIL strobes_exclusive: got read=%0b write=%0b expected not both", mem_read, mem_write);
      end
    end
  end

  typedef struct {
    logic [2:0]  idx;
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  lru;
    logic [23:0] tag;
    logic [23:0] vtag;
    logic [2:0]  exp_way;
    bit          exp_wb;
    int          wb_lat;
    int          fill_lat;
    bit          hold;
  } vec_t;

  vec_t vecs[7];

  // Called at a negedge with the DUT in IDLE; returns at the negedge after UPDATE.
  task automatic do_miss(input vec_t v, input int k);
    logic [191:0] tags;
    for (int w = 0; w < 8; w++) tags[w*24 +: 24] = 24'h100000 + 24'(w);
    tags[v.exp_way*24 +: 24] = v.vtag;
    req_valid = 1'b1; req_index = v.idx; req_tag = v.tag;
    way_valid = v.valid; way_dirty = v.dirty; lru_way = v.lru; way_tags = tags;
    #1;
    chk("accept_ready", req_ready, 1'b1);
    chk("accept_lru_read", lru_read, 1'b1);
    chk("accept_rindex", lru_rindex, v.idx);
    @(negedge clk);
    if (!v.hold) req_valid = 1'b0;
    chk("lookup_ready", req_ready, 1'b0);
    chk("lookup_lru_read", lru_read, 1'b0);
    chk("lookup_way", fill_way, v.exp_way);
    @(negedge clk);
    if (v.exp_wb) begin
      chk("wb_write", mem_write, 1'b1);
      chk("wb_read", mem_read, 1'b0);
      chk("wb_addr", mem_addr, {v.vtag, v.idx, 5'd0});
      chk("wb_wdata", mem_wdata, vline(v.exp_way));
      for (int i = 0; i < v.wb_lat; i++) begin
        @(negedge clk);
        chk("wb_hold_write", mem_write, 1'b1);
        chk("wb_hold_addr", mem_addr, {v.vtag, v.idx, 5'd0});
        chk("wb_hold_wdata", mem_wdata, vline(v.exp_way));
        chk("wb_hold_ready", req_ready, 1'b0);
      end
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
    end
    chk("fill_read", mem_read, 1'b1);
    chk("fill_write", mem_write, 1'b0);
    chk("fill_addr", mem_addr, {v.tag, v.idx, 5'd0});
    for (int i = 0; i < v.fill_lat; i++) begin
      @(negedge clk);
      chk("fill_hold_read", mem_read, 1'b1);
      chk("fill_hold_addr", mem_addr, {v.tag, v.idx, 5'd0});
      chk("fill_hold_ready", req_ready, 1'b0);
    end
    mem_rdata = fline(k);
    mem_resp  = 1'b1;
    @(negedge clk);
    mem_resp  = 1'b0;
    chk("upd_fill_we", fill_we, 1'b1);
    chk("upd_fill_index", fill_index, v.idx);
    chk("upd_fill_way", fill_way, v.exp_way);
    chk("upd_fill_tag", fill_tag, v.tag);
    chk("upd_fill_data", fill_data, fline(k));
    chk("upd_lru_load", lru_load, 1'b1);
    chk("upd_lru_windex", lru_windex, v.idx);
    chk("upd_lru_datain", lru_datain, v.exp_way);
    chk("upd_miss_done", miss_done, 1'b1);
    chk("upd_mem_read", mem_read, 1'b0);
    chk("upd_ready", req_ready, 1'b0);
    chk("upd_lru_read", lru_read, 1'b0);
    @(negedge clk);
    chk("done_pulse", miss_done, 1'b0);
    chk("done_fill_we", fill_we, 1'b0);
    chk("done_lru_load", lru_load, 1'b0);
    chk("done_ready", req_ready, 1'b1);
  endtask

  initial begin
    //           idx   valid  dirty  lru   tag          vtag         way   wb    wbl fl  hold
    vecs[0] = '{3'd5, 8'hFF, 8'h00, 3'd6, 24'hABCDEF, 24'h111111, 3'd6, 1'b0, 0,  2, 1'b0};
    vecs[1] = '{3'd2, 8'hF7, 8'h08, 3'd0, 24'h123456, 24'h333333, 3'd3, 1'b0, 0,  0, 1'b0};
    vecs[2] = '{3'd1, 8'hFF, 8'h10, 3'd4, 24'h0F0F0F, 24'h000123, 3'd4, 1'b1, 1,  1, 1'b0};
    vecs[3] = '{3'd4, 8'hFF, 8'h04, 3'd2, 24'h222222, 24'hBEEF01, 3'd2, 1'b1, 10, 3, 1'b1};
    vecs[4] = '{3'd0, 8'h00, 8'hFF, 3'd7, 24'h000001, 24'h444444, 3'd0, 1'b0, 0,  0, 1'b1};
    vecs[5] = '{3'd7, 8'hFF, 8'hFF, 3'd7, 24'hFFFFFF, 24'hFEDCBA, 3'd7, 1'b1, 0,  0, 1'b0};
    vecs[6] = '{3'd3, 8'h7F, 8'h00, 3'd2, 24'h00AA55, 24'h555555, 3'd7, 1'b0, 0,  1, 1'b0};

    rst = 1'b0; req_valid = 1'b0; req_index = '0; req_tag = '0;
    lru_way = '0; way_valid = '0; way_dirty = '0; way_tags = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    #2;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_fill_we", fill_we, 1'b0);
    chk("rst_lru_load", lru_load, 1'b0);
    chk("rst_miss_done", miss_done, 1'b0);
    chk("rst_fill_tag", fill_tag, 24'h0);
    chk("rst_fill_data", fill_data, 256'h0);
    chk("rst_fill_index", fill_index, 3'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      do_miss(vecs[k], k);
      if (!vecs[k].hold) req_valid = 1'b0;
    end
    req_valid = 1'b0;

    // Stray memory response while idle.
    @(negedge clk);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("stray_ready", req_ready, 1'b1);
    chk("stray_fill_we", fill_we, 1'b0);
    chk("stray_mem_read", mem_read, 1'b0);
    chk("stray_done", miss_done, 1'b0);
    chk("stray_lru_load", lru_load, 1'b0);

    // Asynchronous reset in the middle of a fill.
    req_valid = 1'b1; req_index = 3'd6; req_tag = 24'h777777;
    way_valid = 8'hFF; way_dirty = 8'h00; lru_way = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("arst_pre_read", mem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_read", mem_read, 1'b0);
    chk("arst_ready", req_ready, 1'b1);
    chk("arst_fill_tag", fill_tag, 24'h0);
    chk("arst_fill_way", fill_way, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", req_ready, 1'b1);
    @(negedge clk);
    mem_rdata = fline(99);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("arst_late_fill_we", fill_we, 1'b0);
    chk("arst_late_done", miss_done, 1'b0);
    chk("arst_late_read", mem_read, 1'b0);
    @(negedge clk);
    chk("arst_late_fill_we2", fill_we, 1'b0);
    chk("arst_late_ready2", req_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
